// File: rtl/ad4003_acq_sequencer_pkg.sv
// acq_pkg: shared constants, FSM state encoding and a sizing helper for the AD4003 sequencer.
package acq_pkg;
    localparam int CONV_CYCLES    = 48;
    localparam int ADC_DATA_WIDTH = 18;
    localparam int CFG_WIDTH      = 16;
    localparam int MIN_PERIOD     = CONV_CYCLES + 2 * ADC_DATA_WIDTH + 2;

    typedef enum logic [2:0] {IDLE, CONV, READ, DONE, WRITE, WACK} state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction
endpackage

// File: rtl/ad4003_acq_sequencer_if.sv
// ad4003_acq_sequencer_if: host control/status and ADC pin bundle for the acquisition sequencer.
interface ad4003_acq_sequencer_if
    import acq_pkg::*;
#(
    parameter int CFG_WIDTH = acq_pkg::CFG_WIDTH
);
    logic                 acq_en;
    logic [15:0]          period;
    logic                 cfg_wr_req;
    logic [CFG_WIDTH-1:0] cfg_word;
    logic                 cfg_wr_ack;
    logic                 cnvst;
    logic                 sck;
    logic                 sdi;
    logic                 reader_en_sync;
    logic                 sample_strobe;
    logic [31:0]          sample_cnt;
    logic                 overrun;
    logic                 busy;

    modport master (
        output acq_en, period, cfg_wr_req, cfg_word,
        input  cfg_wr_ack, cnvst, sck, sdi, reader_en_sync, sample_strobe, sample_cnt, overrun, busy
    );

    modport slave (
        input  acq_en, period, cfg_wr_req, cfg_word,
        output cfg_wr_ack, cnvst, sck, sdi, reader_en_sync, sample_strobe, sample_cnt, overrun, busy
    );
endinterface

// File: rtl/ad4003_acq_sequencer_period_timer.sv
// acq_period_timer: free-running sample period counter; tick marks the wrap cycle, held at 0 when disabled.
module acq_period_timer (
    input  logic        adc_spi_clk,
    input  logic        rstn,
    input  logic        en,
    input  logic [15:0] period,
    output logic        tick
);
    logic [15:0] cnt;
    logic [15:0] last;

    // Periods of 0 and 1 behave as 2; >= keeps a shrunk period from running away.
    assign last = (period < 16'd2) ? 16'd1 : period - 16'd1;
    assign tick = en && (cnt >= last);

    always_ff @(posedge adc_spi_clk or negedge rstn) begin
        if (!rstn) cnt <= '0;
        else       cnt <= (tick || !en) ? '0 : cnt + 16'd1;
    end
endmodule

// File: rtl/ad4003_acq_sequencer.sv
// ad4003_acq_sequencer: periodic CNVST/readback sequencing plus MSB-first register writes for an AD4003.
// All pin and status outputs are registered from the next state, so they align with the state change.
module ad4003_acq_sequencer
    import acq_pkg::*;
#(
    parameter int CONV_CYCLES    = acq_pkg::CONV_CYCLES,
    parameter int ADC_DATA_WIDTH = acq_pkg::ADC_DATA_WIDTH,
    parameter int CFG_WIDTH      = acq_pkg::CFG_WIDTH
) (
    input logic                   adc_spi_clk,
    input logic                   rstn,
    ad4003_acq_sequencer_if.slave bus
);
    localparam int CW = $clog2(max3(CONV_CYCLES, 2 * ADC_DATA_WIDTH, 2 * CFG_WIDTH) + 1);
    localparam logic [CW-1:0] CONV_LAST  = CW'(CONV_CYCLES - 1);
    localparam logic [CW-1:0] READ_LAST  = CW'(2 * ADC_DATA_WIDTH - 1);
    localparam logic [CW-1:0] WRITE_LAST = CW'(2 * CFG_WIDTH - 1);

    state_t               st, nst;
    logic [CW-1:0]        cyc, ncyc;
    logic [CFG_WIDTH-1:0] sh, sh_d;
    logic                 tick, acq_q, rise, sdi_d;

    acq_period_timer u_timer (
        .adc_spi_clk (adc_spi_clk),
        .rstn        (rstn),
        .en          (bus.acq_en),
        .period      (bus.period),
        .tick        (tick)
    );

    assign rise = bus.acq_en && !acq_q;

    always_ff @(posedge adc_spi_clk or negedge rstn) begin
        if (!rstn) begin
            st  <= IDLE;
            cyc <= '0;
        end else begin
            st  <= nst;
            cyc <= ncyc;
        end
    end

    // A tick always wins in IDLE; a pending write request waits for the next IDLE cycle.
    always_comb begin
        nst  = st;
        ncyc = cyc + 1'b1;
        case (st)
            IDLE: begin
                ncyc = '0;
                nst  = tick ? CONV : bus.cfg_wr_req ? WRITE : IDLE;
            end
            CONV: if (cyc == CONV_LAST) begin
                nst  = READ;
                ncyc = '0;
            end
            READ:    if (cyc == READ_LAST) nst = DONE;
            DONE:    nst = IDLE;
            WRITE:   if (cyc == WRITE_LAST) nst = WACK;
            WACK:    nst = IDLE;
            default: nst = IDLE;
        endcase
    end

    // Even cycles are SCK low phases; SDI moves to the next word bit only at the start of a low phase.
    always_comb begin
        sh_d  = (st == IDLE) ? bus.cfg_word : (st == WRITE && !ncyc[0]) ? sh << 1 : sh;
        sdi_d = (nst != WRITE) ? 1'b1
              : (st == IDLE)   ? bus.cfg_word[CFG_WIDTH-1]
              : ncyc[0]        ? bus.sdi
              :                  sh[CFG_WIDTH-2];
    end

    always_ff @(posedge adc_spi_clk or negedge rstn) begin
        if (!rstn) begin
            sh                 <= '0;
            acq_q              <= 1'b0;
            bus.cnvst          <= 1'b0;
            bus.sck            <= 1'b0;
            bus.sdi            <= 1'b1;
            bus.reader_en_sync <= 1'b0;
            bus.sample_strobe  <= 1'b0;
            bus.cfg_wr_ack     <= 1'b0;
            bus.busy           <= 1'b0;
            bus.overrun        <= 1'b0;
            bus.sample_cnt     <= '0;
        end else begin
            sh                 <= sh_d;
            acq_q              <= bus.acq_en;
            bus.cnvst          <= nst == CONV;
            bus.sck            <= (nst == READ || nst == WRITE) && ncyc[0];
            bus.sdi            <= sdi_d;
            bus.reader_en_sync <= nst == READ;
            bus.sample_strobe  <= nst == DONE;
            bus.cfg_wr_ack     <= nst == WACK;
            bus.busy           <= nst != IDLE;
            if (rise) begin
                bus.overrun    <= 1'b0;
                bus.sample_cnt <= '0;
            end else begin
                if (tick && st != IDLE) bus.overrun    <= 1'b1;
                if (nst == DONE)        bus.sample_cnt <= bus.sample_cnt + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_ad4003_acq_sequencer.sv
// tb_ad4003_acq_sequencer: directed scenarios plus random traffic against a timeline model of
// each conversion/write job expressed as offsets from its start.
module tb_ad4003_acq_sequencer;
    import acq_pkg::*;

    localparam int C  = CONV_CYCLES;
    localparam int A  = ADC_DATA_WIDTH;
    localparam int W  = CFG_WIDTH;
    localparam int LC = C + 2 * A + 1;
    localparam int LW = 2 * W + 1;

    logic adc_spi_clk = 1'b0;
    logic rstn = 1'b0;

    ad4003_acq_sequencer_if bus ();

    ad4003_acq_sequencer dut (
        .adc_spi_clk (adc_spi_clk),
        .rstn        (rstn),
        .bus         (bus)
    );

    always #5 adc_spi_clk = ~adc_spi_clk;

    int checks = 0;
    int errors = 0;

    int          m_pc, m_job, m_k;
    bit          m_prev, m_ovr;
    logic [31:0] m_cnt;
    logic [W-1:0] m_word;

    int           n_strobe, n_ack, n_cnv, n_ren, n_sckr, cyc_no, t_strobe, t_ack, n0;
    logic [W-1:0] bits;
    logic         sck_prev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] dut_outs();
        return {bus.cnvst, bus.sck, bus.sdi, bus.reader_en_sync,
                bus.sample_strobe, bus.cfg_wr_ack, bus.busy, bus.overrun};
    endfunction

    task automatic model_reset();
        m_pc = 0; m_job = 0; m_k = 0; m_prev = 0; m_ovr = 0; m_cnt = '0; m_word = '0;
        sck_prev = 1'b0;
    endtask

    // One clock edge of the reference: job 1 = conversion, job 2 = register write, k = cycles since start.
    task automatic model_step();
        int p;
        bit tk, rs;
        p  = (bus.period < 16'd2) ? 2 : int'(bus.period);
        tk = bus.acq_en && (m_pc >= p - 1);
        rs = bus.acq_en && !m_prev;
        if (rs) m_ovr = 0;
        else if (tk && m_job != 0) m_ovr = 1;
        if (m_job != 0) begin
            if (m_k == ((m_job == 1) ? LC : LW)) m_job = 0;
            else m_k++;
        end else if (tk) begin
            m_job = 1; m_k = 1;
        end else if (bus.cfg_wr_req) begin
            m_job = 2; m_k = 1; m_word = bus.cfg_word;
        end
        if (rs) m_cnt = '0;
        else if (m_job == 1 && m_k == LC) m_cnt = m_cnt + 32'd1;
        m_pc   = bus.acq_en ? (tk ? 0 : m_pc + 1) : 0;
        m_prev = bus.acq_en;
    endtask

    task automatic compare_all();
        bit conv, wr, ren, sck, sdi;
        int idx;
        conv = m_job == 1;
        wr   = m_job == 2;
        ren  = conv && m_k > C && m_k <= C + 2 * A;
        sck  = (ren && (m_k - C - 1) % 2 == 1) || (wr && m_k <= 2 * W && (m_k - 1) % 2 == 1);
        idx  = (wr && m_k <= 2 * W) ? W - 1 - (m_k - 1) / 2 : -1;
        sdi  = (idx >= 0) ? m_word[idx] : 1'b1;
        check("outputs", 32'(dut_outs()),
              32'({conv && m_k <= C, sck, sdi, ren, conv && m_k == LC, wr && m_k == LW, m_job != 0, m_ovr}));
        check("sample_cnt", bus.sample_cnt, m_cnt);
    endtask

    task automatic cycle();
        @(posedge adc_spi_clk);
        #1;
        model_step();
        compare_all();
        cyc_no++;
        n_strobe += int'(bus.sample_strobe);
        n_ack    += int'(bus.cfg_wr_ack);
        n_cnv    += int'(bus.cnvst);
        n_ren    += int'(bus.reader_en_sync);
        if (bus.sample_strobe) t_strobe = cyc_no;
        if (bus.cfg_wr_ack) begin
            t_ack = cyc_no;
            bus.cfg_wr_req = 1'b0;
        end
        if (bus.sck && !sck_prev) begin
            n_sckr++;
            bits = {bits[W-2:0], bus.sdi};
        end
        sck_prev = bus.sck;
    endtask

    task automatic clear_counts();
        n_strobe = 0; n_ack = 0; n_cnv = 0; n_ren = 0; n_sckr = 0; bits = '0;
    endtask

    initial begin
        bus.acq_en = 1'b0; bus.period = 16'd100; bus.cfg_wr_req = 1'b0; bus.cfg_word = '0;
        cyc_no = 0; t_strobe = 0; t_ack = 0;
        model_reset();
        clear_counts();
        repeat (3) @(posedge adc_spi_clk);
        #1;
        check("reset_outs", 32'(dut_outs()), 32'h20);
        check("reset_cnt", bus.sample_cnt, 32'h0);
        #2 rstn = 1'b1;

        // Clean periodic acquisition, then let the last sample finish with acq_en low.
        bus.acq_en = 1'b1;
        repeat (1000) cycle();
        bus.acq_en = 1'b0;
        repeat (100) cycle();
        check("s1_strobes", n_strobe, 10);
        check("s1_cnvst_cycles", n_cnv, 10 * 48);
        check("s1_sck_pulses", n_sckr, 10 * 18);
        check("s1_reader_cycles", n_ren, 10 * 36);
        check("s1_overrun", 32'(bus.overrun), 0);
        check("s1_cnt", bus.sample_cnt, 10);

        // Period too short: every other tick is dropped.
        clear_counts();
        bus.period = 16'd80;
        bus.acq_en = 1'b1;
        repeat (300) cycle();
        check("s2_overrun_set", 32'(bus.overrun), 1);
        bus.acq_en = 1'b0;
        repeat (100) cycle();
        check("s2_strobes", n_strobe, 2);
        check("s2_overrun_sticky", 32'(bus.overrun), 1);
        check("s2_cnt", bus.sample_cnt, 2);
        bus.acq_en = 1'b1;
        cycle();
        check("s2_overrun_clr", 32'(bus.overrun), 0);
        check("s2_cnt_clr", bus.sample_cnt, 0);
        bus.acq_en = 1'b0;
        repeat (5) cycle();

        // Register write with acquisition off.
        clear_counts();
        bus.cfg_word   = 16'h14A5;
        bus.cfg_wr_req = 1'b1;
        for (int i = 0; i < 100 && n_ack == 0; i++) cycle();
        repeat (5) cycle();
        check("s3_acks", n_ack, 1);
        check("s3_sck_pulses", n_sckr, 16);
        check("s3_sdi_bits", 32'(bits), 32'h14A5);
        check("s3_sdi_idle", 32'(bus.sdi), 1);
        check("s3_busy", 32'(bus.busy), 0);

        // Tick and write request in the same cycle: sample first, write right after.
        clear_counts();
        bus.period = 16'd200;
        bus.acq_en = 1'b1;
        for (int i = 0; i < 400 && m_pc != 199; i++) cycle();
        bus.cfg_word   = W'($urandom);
        bus.cfg_wr_req = 1'b1;
        t_strobe = 0; t_ack = 0;
        for (int i = 0; i < 200 && t_ack == 0; i++) cycle();
        check("s4_strobe_seen", n_strobe, 1);
        check("s4_ack_gap", t_ack - t_strobe, 2 + 2 * W);
        check("s4_overrun", 32'(bus.overrun), 0);
        bus.acq_en = 1'b0;
        repeat (120) cycle();

        // Reset in the middle of READ.
        clear_counts();
        bus.period = 16'd100;
        bus.acq_en = 1'b1;
        for (int i = 0; i < 300 && n_strobe == 0; i++) cycle();
        for (int i = 0; i < 200 && !(m_job == 1 && m_k == C + 20); i++) cycle();
        check("s5_cnt_before", bus.sample_cnt, 1);
        check("s5_reading", 32'(bus.reader_en_sync), 1);
        rstn = 1'b0;
        #1;
        check("s5_reset_outs", 32'(dut_outs()), 32'h20);
        check("s5_reset_cnt", bus.sample_cnt, 0);
        model_reset();
        #3 rstn = 1'b1;
        clear_counts();
        repeat (300) cycle();
        check("s5_resume_strobes", n_strobe, 2);

        // Counter wrap from a forced all-ones value.
        for (int i = 0; i < 200 && m_job != 0; i++) cycle();
        force bus.sample_cnt = 32'hFFFF_FFFF;
        #1;
        release bus.sample_cnt;
        m_cnt = 32'hFFFF_FFFF;
        check("s6_preset", bus.sample_cnt, 32'hFFFF_FFFF);
        n0 = n_strobe;
        for (int i = 0; i < 300 && n_strobe == n0; i++) cycle();
        check("s6_wrapped", bus.sample_cnt, 32'h0);
        check("s6_strobe_seen", n_strobe - n0, 1);

        // Random traffic: enable toggles, short/long/degenerate periods, writes with a changing word.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) bus.acq_en = !bus.acq_en;
            if (!bus.acq_en && $urandom_range(0, 49) == 0)
                bus.period = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom_range(40, 260));
            if (!bus.cfg_wr_req && $urandom_range(0, 149) == 0) bus.cfg_wr_req = 1'b1;
            bus.cfg_word = W'($urandom);
            cycle();
        end
        bus.acq_en = 1'b0;
        repeat (200) cycle();
        check("final_busy", 32'(bus.busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ad4003_acq_sequencer.md
AD4003_ACQ_SEQUENCER -- requirements
Module: ad4003_acq_sequencer

Interface
REQ-001 Parameter CONV_CYCLES, default 48: cnvst high time in clocks (600 ns at 80 MHz).
REQ-002 Parameter ADC_DATA_WIDTH, default 18: number of sck pulses per sample read.
REQ-003 Parameter CFG_WIDTH, default 16: number of sck pulses per register write (8-bit command followed by 8-bit data).
REQ-004 Port adc_spi_clk, in, 1: single clock (80 MHz); all logic is on its rising edge.
REQ-005 Port rstn, in, 1: reset, asynchronous, active-low.
REQ-006 Port acq_en, in, 1: level; enables periodic acquisition.
REQ-007 Port period, in, 16: sample period in clocks.
REQ-008 Port cfg_wr_req, in, 1: level; requests a register write.
REQ-009 Port cfg_word, in, CFG_WIDTH: write word, sent MSB first.
REQ-010 Port cfg_wr_ack, out, 1: one-cycle pulse when the write completes.
REQ-011 Port cnvst, out, 1: ADC convert start.
REQ-012 Port sck, out, 1: ADC serial clock.
REQ-013 Port sdi, out, 1: ADC serial data in.
REQ-014 Port reader_en_sync, out, 1: high during the sample read window; drives the deserializers.
REQ-015 Port sample_strobe, out, 1: one-cycle pulse per completed sample.
REQ-016 Port sample_cnt, out, 32: completed samples since acq_en last rose.
REQ-017 Port overrun, out, 1: sticky flag; a period tick was missed.
REQ-018 Port busy, out, 1: high whenever state is not IDLE.

Function
REQ-019 Period counter SHALL count 0..period-1 and wrap while acq_en=1, be held at 0 while acq_en=0, and assert tick in the cycle it wraps.
REQ-020 Period values below 2 SHALL be treated as 2.
REQ-021 The FSM SHALL have the states IDLE, CONV, READ, DONE, WRITE and WACK.
REQ-022 IDLE -> CONV on tick.
REQ-023 IDLE -> WRITE on cfg_wr_req when no tick is present.
REQ-024 A tick SHALL win over cfg_wr_req when both occur in the same cycle; the request stays pending.
REQ-025 In CONV, cnvst SHALL be 1 for exactly CONV_CYCLES cycles, then the FSM SHALL go to READ.
REQ-026 All outputs SHALL be registered, so cnvst rises 1 cycle after tick.
REQ-027 In READ, sck SHALL produce ADC_DATA_WIDTH pulses, each lasting 2 cycles: low phase then high phase (40 MHz).
REQ-028 reader_en_sync SHALL be 1 for the whole of READ (2*ADC_DATA_WIDTH cycles) and cnvst SHALL be 0.
REQ-029 After the last high phase, READ -> DONE.
REQ-030 DONE SHALL last 1 cycle: sample_strobe=1, sample_cnt+1 (wraps at 2^32-1 -> 0), then -> IDLE.
REQ-031 In WRITE, sck SHALL produce CFG_WIDTH pulses; sdi SHALL update on each low phase with cfg_word bit CFG_WIDTH-1 down to 0.
REQ-032 cfg_word SHALL be captured on entry to WRITE.
REQ-033 WRITE -> WACK, with cfg_wr_ack=1 for 1 cycle, then -> IDLE.
REQ-034 The requester SHALL drop cfg_wr_req the cycle after ack; a level still high in IDLE starts a new write.
REQ-035 A tick arriving in any state other than IDLE SHALL be dropped and SHALL set overrun; the minimum clean period is CONV_CYCLES + 2*ADC_DATA_WIDTH + 2 = 86 at defaults.
REQ-036 acq_en rising edge SHALL clear overrun and sample_cnt.
REQ-037 acq_en falling during CONV or READ SHALL let the current sample complete; no further ticks are generated.
REQ-038 Idle levels SHALL be cnvst=0, sck=0, sdi=1, reader_en_sync=0.

Reset
REQ-039 rstn=0 SHALL asynchronously force: state IDLE; period counter 0; cnvst, sck, reader_en_sync, sample_strobe, cfg_wr_ack, overrun and busy = 0; sdi=1; sample_cnt=0.
REQ-040 Reset mid-CONV or mid-READ SHALL abort immediately with no strobe or ack.
REQ-041 Release of rstn SHALL take effect on the next rising clock edge.

Structure
REQ-042 Package acq_pkg SHALL hold the FSM state enum, CONV_CYCLES, ADC_DATA_WIDTH, CFG_WIDTH and the minimum-period constant.
REQ-043 The period counter SHALL be the single sub-module acq_period_timer (inputs en, period; output tick); the FSM and shift logic stay in the top.

Verification
REQ-044 Scenario: period=100, acq_en=1 for 1000 cycles -> 10 sample_strobe pulses 100 cycles apart; cnvst high 48 cycles; 18 sck pulses; reader_en_sync high 36 cycles; overrun=0.
REQ-045 Scenario: period=80 -> overrun=1 after the second tick; strobes every 160 cycles; toggling acq_en clears overrun and sample_cnt.
REQ-046 Scenario: acq_en=0, cfg_word=0x14A5, cfg_wr_req=1 -> 16 sck pulses; sdi sampled on sck rising = 0001010010100101; one cfg_wr_ack; sdi returns to 1.
REQ-047 Scenario: tick and cfg_wr_req in the same cycle -> sample completes first, write starts the cycle after IDLE is re-entered, overrun stays 0 with period=200.
REQ-048 Scenario: rstn pulsed low at cycle 20 of READ -> all outputs at reset values within the same cycle, no strobe, sample_cnt=0, normal sampling resumes on the next tick.
REQ-049 Scenario: sample_cnt preset near wrap by forcing 0xFFFFFFFF -> the next DONE gives 0x00000000.
